// File: rtl/snooping_instruction_queue.sv
// Multi-lane in-order instruction queue between dispatch and the reservation
// stations. Waiting entries snoop the CDB every cycle and capture operand
// values in place. Dequeue lanes see same-cycle CDB results combinationally.
module snooping_instruction_queue #(
    parameter int LANES     = 2,
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = 64,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int NUM_CDB   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [LANES-1:0]              enq_vld,
    output logic [LANES-1:0]              enq_rdy,
    input  logic [LANES*PAYLOAD_W-1:0]    enq_payload,
    input  logic [LANES-1:0]              enq_busy1,
    input  logic [LANES-1:0]              enq_busy2,
    input  logic [LANES*DATA_W-1:0]       enq_op1,
    input  logic [LANES*DATA_W-1:0]       enq_op2,
    input  logic [NUM_CDB-1:0]            cdb_vld,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
    output logic [LANES-1:0]              deq_vld,
    input  logic [LANES-1:0]              deq_rdy,
    output logic [LANES*PAYLOAD_W-1:0]    deq_payload,
    output logic [LANES-1:0]              deq_busy1,
    output logic [LANES-1:0]              deq_busy2,
    output logic [LANES*DATA_W-1:0]       deq_op1,
    output logic [LANES*DATA_W-1:0]       deq_op2,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Pointer and occupancy state
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // Entry storage; an entry is live when it lies in [head, head+count)
    logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_r;
    logic [DEPTH-1:0]                busy1_r;
    logic [DEPTH-1:0]                busy2_r;
    logic [DEPTH-1:0][DATA_W-1:0]    op1_r;
    logic [DEPTH-1:0][DATA_W-1:0]    op2_r;

    // Next-state of the entry storage
    logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_nxt_s;
    logic [DEPTH-1:0]                busy1_nxt_s;
    logic [DEPTH-1:0]                busy2_nxt_s;
    logic [DEPTH-1:0][DATA_W-1:0]    op1_nxt_s;
    logic [DEPTH-1:0][DATA_W-1:0]    op2_nxt_s;

    logic [CW-1:0]    free_s;
    logic [CW-1:0]    n_enq_s;
    logic [CW-1:0]    n_deq_s;
    logic [LANES-1:0] enq_acc_s;
    logic [LANES-1:0] deq_fire_s;

    // Circular pointer advance with explicit wrap, so DEPTH need not be 2^k.
    function automatic logic [PW-1:0] wrap_add_f(input logic [PW-1:0] ptr,
                                                 input logic [PW:0]   inc);
        logic [PW:0] sum_v;
        sum_v = {1'b0, ptr} + inc;
        if (sum_v >= (PW+1)'(DEPTH)) begin
            sum_v = sum_v - (PW+1)'(DEPTH);
        end else begin
            sum_v = sum_v;
        end
        return sum_v[PW-1:0];
    endfunction

    // Resolve one operand against the CDB. Returns {busy, op}. When several
    // lanes carry the same tag the highest-index lane is applied last and wins.
    // Non-busy operands are passed through untouched.
    function automatic logic [DATA_W:0] snoop_f(
        input logic                      busy,
        input logic [DATA_W-1:0]         op,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] res_v;
        res_v = {busy, op};
        if (busy) begin
            for (int c = 0; c < NUM_CDB; c++) begin
                if (vld[c] && (op[TAG_W-1:0] == tags[c*TAG_W +: TAG_W])) begin
                    res_v = {1'b0, data[c*DATA_W +: DATA_W]};
                end else begin
                    res_v = res_v;
                end
            end
        end else begin
            res_v = res_v;
        end
        return res_v;
    endfunction

    assign count = count_r;

    // Lane handshakes: readiness from free space, validity from occupancy, both
    // killed during flush; accepted/retired counts are the longest prefixes.
    always_comb begin : handshake_blk
        logic enq_run_v;
        logic deq_run_v;
        free_s     = CW'(DEPTH) - count_r;
        enq_rdy    = '0;
        deq_vld    = '0;
        enq_acc_s  = '0;
        deq_fire_s = '0;
        n_enq_s    = '0;
        n_deq_s    = '0;
        enq_run_v  = 1'b1;
        deq_run_v  = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            enq_rdy[k]    = (CW'(k) < free_s) & ~flush;
            deq_vld[k]    = (CW'(k) < count_r) & ~flush;
            enq_acc_s[k]  = enq_run_v & enq_vld[k] & enq_rdy[k];
            deq_fire_s[k] = deq_run_v & deq_vld[k] & deq_rdy[k];
            enq_run_v     = enq_acc_s[k];
            deq_run_v     = deq_fire_s[k];
            n_enq_s       = n_enq_s + CW'(enq_acc_s[k]);
            n_deq_s       = n_deq_s + CW'(deq_fire_s[k]);
        end
    end

    // Entry next-state: every slot snoops the CDB, then accepted lanes are
    // written (already snooped) at tail+k.
    always_comb begin : entry_nxt_blk
        logic [PW-1:0] idx_v;
        payload_nxt_s = payload_r;
        busy1_nxt_s   = '0;
        busy2_nxt_s   = '0;
        op1_nxt_s     = '0;
        op2_nxt_s     = '0;
        idx_v         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            {busy1_nxt_s[i], op1_nxt_s[i]} = snoop_f(busy1_r[i], op1_r[i], cdb_vld, cdb_tag, cdb_data);
            {busy2_nxt_s[i], op2_nxt_s[i]} = snoop_f(busy2_r[i], op2_r[i], cdb_vld, cdb_tag, cdb_data);
        end
        for (int k = 0; k < LANES; k++) begin
            if (enq_acc_s[k]) begin
                idx_v = wrap_add_f(tail_r, (PW+1)'(k));
                payload_nxt_s[idx_v] = enq_payload[k*PAYLOAD_W +: PAYLOAD_W];
                {busy1_nxt_s[idx_v], op1_nxt_s[idx_v]} =
                    snoop_f(enq_busy1[k], enq_op1[k*DATA_W +: DATA_W], cdb_vld, cdb_tag, cdb_data);
                {busy2_nxt_s[idx_v], op2_nxt_s[idx_v]} =
                    snoop_f(enq_busy2[k], enq_op2[k*DATA_W +: DATA_W], cdb_vld, cdb_tag, cdb_data);
            end else begin
                idx_v = idx_v;
            end
        end
    end

    // Dequeue lanes: entry head+k with same-cycle CDB bypass; zero when invalid.
    always_comb begin : deq_out_blk
        logic [PW-1:0] idx_v;
        deq_payload = '0;
        deq_busy1   = '0;
        deq_busy2   = '0;
        deq_op1     = '0;
        deq_op2     = '0;
        idx_v       = '0;
        for (int k = 0; k < LANES; k++) begin
            if (deq_vld[k]) begin
                idx_v = wrap_add_f(head_r, (PW+1)'(k));
                deq_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_r[idx_v];
                {deq_busy1[k], deq_op1[k*DATA_W +: DATA_W]} =
                    snoop_f(busy1_r[idx_v], op1_r[idx_v], cdb_vld, cdb_tag, cdb_data);
                {deq_busy2[k], deq_op2[k*DATA_W +: DATA_W]} =
                    snoop_f(busy2_r[idx_v], op2_r[idx_v], cdb_vld, cdb_tag, cdb_data);
            end else begin
                idx_v = idx_v;
            end
        end
    end

    // Pointer/occupancy register; flush empties the queue and drops enqueues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= wrap_add_f(head_r, (PW+1)'(n_deq_s));
            tail_r  <= wrap_add_f(tail_r, (PW+1)'(n_enq_s));
            count_r <= count_r + n_enq_s - n_deq_s;
        end
    end

    // Entry storage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_r <= '0;
            busy1_r   <= '0;
            busy2_r   <= '0;
            op1_r     <= '0;
            op2_r     <= '0;
        end else begin
            payload_r <= payload_nxt_s;
            busy1_r   <= busy1_nxt_s;
            busy2_r   <= busy2_nxt_s;
            op1_r     <= op1_nxt_s;
            op2_r     <= op2_nxt_s;
        end
    end

endmodule

// File: tb/tb_snooping_instruction_queue.sv
// Self-checking bench: queue-based reference model of the snooping queue,
// compared against the DUT every cycle, plus directed literal checks.
module tb_snooping_instruction_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 5;
    localparam int PW_L  = 16;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int NC    = 2;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [LANES-1:0]   enq_vld;
    logic [LANES-1:0]   enq_rdy;
    logic [LANES*PW_L-1:0] enq_payload;
    logic [LANES-1:0]   enq_busy1, enq_busy2;
    logic [LANES*DW-1:0] enq_op1, enq_op2;
    logic [NC-1:0]      cdb_vld;
    logic [NC*TW-1:0]   cdb_tag;
    logic [NC*DW-1:0]   cdb_data;
    logic [LANES-1:0]   deq_vld;
    logic [LANES-1:0]   deq_rdy;
    logic [LANES*PW_L-1:0] deq_payload;
    logic [LANES-1:0]   deq_busy1, deq_busy2;
    logic [LANES*DW-1:0] deq_op1, deq_op2;
    logic [2:0]         count;

    snooping_instruction_queue #(
        .LANES(LANES), .DEPTH(DEPTH), .PAYLOAD_W(PW_L),
        .DATA_W(DW), .TAG_W(TW), .NUM_CDB(NC)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_payload(enq_payload),
        .enq_busy1(enq_busy1), .enq_busy2(enq_busy2),
        .enq_op1(enq_op1), .enq_op2(enq_op2),
        .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .deq_vld(deq_vld), .deq_rdy(deq_rdy), .deq_payload(deq_payload),
        .deq_busy1(deq_busy1), .deq_busy2(deq_busy2),
        .deq_op1(deq_op1), .deq_op2(deq_op2),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [PW_L-1:0] pl;
        logic            b1;
        logic [DW-1:0]   o1;
        logic            b2;
        logic [DW-1:0]   o2;
    } ent_t;

    ent_t mq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand after the current CDB: scan lanes from highest index down.
    function automatic logic [DW:0] msnoop(input logic b, input logic [DW-1:0] o);
        if (!b) return {1'b0, o};
        for (int c = NC - 1; c >= 0; c--) begin
            if (cdb_vld[c] && cdb_tag[c*TW +: TW] == o[TW-1:0])
                return {1'b0, cdb_data[c*DW +: DW]};
        end
        return {1'b1, o};
    endfunction

    task automatic check_outputs();
        logic [LANES-1:0] e_rdy, e_vld, e_b1, e_b2;
        logic [LANES*PW_L-1:0] e_pl;
        logic [LANES*DW-1:0] e_o1, e_o2;
        logic [DW:0] r;
        int sz;
        sz = mq.size();
        e_rdy = '0; e_vld = '0; e_b1 = '0; e_b2 = '0; e_pl = '0; e_o1 = '0; e_o2 = '0;
        for (int k = 0; k < LANES; k++) begin
            e_rdy[k] = (k < DEPTH - sz) && !flush;
            e_vld[k] = (k < sz) && !flush;
            if (e_vld[k]) begin
                e_pl[k*PW_L +: PW_L] = mq[k].pl;
                r = msnoop(mq[k].b1, mq[k].o1);
                e_b1[k] = r[DW]; e_o1[k*DW +: DW] = r[DW-1:0];
                r = msnoop(mq[k].b2, mq[k].o2);
                e_b2[k] = r[DW]; e_o2[k*DW +: DW] = r[DW-1:0];
            end
        end
        chk("model_count", 64'(count), 64'(sz));
        chk("model_enq_rdy", 64'(enq_rdy), 64'(e_rdy));
        chk("model_deq_vld", 64'(deq_vld), 64'(e_vld));
        chk("model_deq_payload", 64'(deq_payload), 64'(e_pl));
        chk("model_deq_busy1", 64'(deq_busy1), 64'(e_b1));
        chk("model_deq_busy2", 64'(deq_busy2), 64'(e_b2));
        chk("model_deq_op1", 64'(deq_op1), 64'(e_o1));
        chk("model_deq_op2", 64'(deq_op2), 64'(e_o2));
    endtask

    task automatic model_update();
        int sz, n, m;
        ent_t e;
        logic [DW:0] r;
        sz = mq.size();
        if (flush) begin
            mq.delete();
            return;
        end
        n = 0;
        m = 0;
        for (int k = 0; k < LANES; k++) begin
            if (enq_vld[k] && n == k && k < DEPTH - sz) n++;
            if (deq_rdy[k] && m == k && k < sz) m++;
        end
        repeat (m) void'(mq.pop_front());
        foreach (mq[i]) begin
            r = msnoop(mq[i].b1, mq[i].o1); mq[i].b1 = r[DW]; mq[i].o1 = r[DW-1:0];
            r = msnoop(mq[i].b2, mq[i].o2); mq[i].b2 = r[DW]; mq[i].o2 = r[DW-1:0];
        end
        for (int k = 0; k < n; k++) begin
            e.pl = enq_payload[k*PW_L +: PW_L];
            r = msnoop(enq_busy1[k], enq_op1[k*DW +: DW]); e.b1 = r[DW]; e.o1 = r[DW-1:0];
            r = msnoop(enq_busy2[k], enq_op2[k*DW +: DW]); e.b2 = r[DW]; e.o2 = r[DW-1:0];
            mq.push_back(e);
        end
    endtask

    // Inputs are driven at posedge+1; compare at +2..+3, then take the edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; enq_vld = '0; deq_rdy = '0; cdb_vld = '0;
        enq_payload = '0; enq_busy1 = '0; enq_busy2 = '0; enq_op1 = '0; enq_op2 = '0;
        cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_enq(input int k, input logic [PW_L-1:0] pl, input logic b1,
                           input logic [DW-1:0] o1, input logic b2, input logic [DW-1:0] o2);
        enq_vld[k] = 1'b1;
        enq_payload[k*PW_L +: PW_L] = pl;
        enq_busy1[k] = b1; enq_op1[k*DW +: DW] = o1;
        enq_busy2[k] = b2; enq_op2[k*DW +: DW] = o2;
    endtask

    task automatic set_cdb(input int c, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        cdb_vld[c] = 1'b1;
        cdb_tag[c*TW +: TW] = tag;
        cdb_data[c*DW +: DW] = data;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        // Reset state
        @(posedge clk);
        #1;
        chk("reset_enq_rdy", 64'(enq_rdy), 64'h3);
        chk("reset_deq_vld", 64'(deq_vld), 64'h0);
        chk("reset_count", 64'(count), 64'h0);
        chk("reset_deq_op1", 64'(deq_op1), 64'h0);
        rst = 1'b1;

        // Fill to full, then drain across the wrap
        idle();
        set_enq(0, 16'h0100, 1'b0, 32'h10, 1'b0, 32'h20);
        set_enq(1, 16'h0101, 1'b0, 32'h11, 1'b0, 32'h21);
        cycle();
        chk("fill_count_2", 64'(count), 64'd2);
        set_enq(0, 16'h0102, 1'b0, 32'h12, 1'b0, 32'h22);
        set_enq(1, 16'h0103, 1'b0, 32'h13, 1'b0, 32'h23);
        cycle();
        chk("fill_count_4", 64'(count), 64'd4);
        set_enq(0, 16'h0104, 1'b0, 32'h14, 1'b0, 32'h24);
        set_enq(1, 16'h0105, 1'b0, 32'h15, 1'b0, 32'h25);
        #1;
        chk("fill_enq_rdy_01", 64'(enq_rdy), 64'h1);
        cycle();
        chk("fill_count_5", 64'(count), 64'd5);
        chk("full_enq_rdy_00", 64'(enq_rdy), 64'h0);
        idle();
        deq_rdy = 2'b11;
        #1;
        chk("drain_pl_0", 64'(deq_payload), 64'h0101_0100);
        cycle();
        chk("drain_count_3", 64'(count), 64'd3);
        chk("drain_pl_1", 64'(deq_payload), 64'h0103_0102);
        cycle();
        chk("drain_count_1", 64'(count), 64'd1);
        chk("drain_vld_01", 64'(deq_vld), 64'h1);
        chk("drain_pl_2", 64'(deq_payload), 64'h0000_0104);
        cycle();
        chk("drain_count_0", 64'(count), 64'd0);
        idle();
        set_enq(0, 16'h0106, 1'b0, 32'h16, 1'b0, 32'h26);
        set_enq(1, 16'h0107, 1'b0, 32'h17, 1'b0, 32'h27);
        cycle();
        idle();
        deq_rdy = 2'b11;
        #1;
        chk("wrap_pl", 64'(deq_payload), 64'h0107_0106);
        cycle();
        chk("wrap_count_0", 64'(count), 64'd0);

        // Prefix gaps
        idle();
        set_enq(1, 16'h0200, 1'b0, 32'h1, 1'b0, 32'h2);
        cycle();
        chk("gap_enq_none", 64'(count), 64'd0);
        idle();
        set_enq(0, 16'h0201, 1'b0, 32'h1, 1'b0, 32'h2);
        set_enq(1, 16'h0202, 1'b0, 32'h3, 1'b0, 32'h4);
        cycle();
        idle();
        deq_rdy = 2'b10;
        cycle();
        chk("gap_deq_none", 64'(count), 64'd2);
        deq_rdy = 2'b11;
        cycle();

        // In-place capture, non-matching tag first
        idle();
        set_enq(0, 16'h0300, 1'b1, 32'h7, 1'b0, 32'h55);
        cycle();
        idle();
        repeat (3) cycle();
        set_cdb(1, 4'h6, 32'h1234_5678);
        #1;
        chk("nomatch_bypass_busy", 64'(deq_busy1), 64'h1);
        cycle();
        idle();
        chk("nomatch_busy1", 64'(deq_busy1), 64'h1);
        chk("nomatch_op1", 64'(deq_op1), 64'h7);
        set_cdb(1, 4'h7, 32'hDEAD_BEEF);
        #1;
        chk("capture_bypass_busy", 64'(deq_busy1), 64'h0);
        cycle();
        idle();
        chk("capture_busy1", 64'(deq_busy1), 64'h0);
        chk("capture_op1", 64'(deq_op1), 64'hDEAD_BEEF);
        chk("capture_op2", 64'(deq_op2), 64'h55);
        deq_rdy = 2'b01;
        cycle();

        // Same-cycle races
        idle();
        set_enq(0, 16'h0400, 1'b1, 32'h3, 1'b0, 32'h1);
        set_cdb(0, 4'h3, 32'hCAFE_F00D);
        cycle();
        idle();
        chk("race_enq_busy1", 64'(deq_busy1), 64'h0);
        chk("race_enq_op1", 64'(deq_op1), 64'hCAFE_F00D);
        deq_rdy = 2'b01;
        cycle();
        idle();
        set_enq(0, 16'h0500, 1'b0, 32'h2, 1'b1, 32'h9);
        cycle();
        idle();
        deq_rdy = 2'b01;
        set_cdb(0, 4'h9, 32'h0BAD_CAFE);
        set_cdb(1, 4'h9, 32'h1111_2222);
        #1;
        chk("race_deq_busy2", 64'(deq_busy2), 64'h0);
        chk("race_deq_op2", 64'(deq_op2), 64'h1111_2222);
        cycle();
        chk("race_deq_count", 64'(count), 64'd0);

        // Flush with simultaneous enqueue
        idle();
        set_enq(0, 16'h0600, 1'b0, 32'h0, 1'b0, 32'h0);
        set_enq(1, 16'h0601, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        set_enq(0, 16'h0602, 1'b0, 32'h0, 1'b0, 32'h0);
        set_enq(1, 16'h0603, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        chk("flush_pre_count", 64'(count), 64'd4);
        set_enq(0, 16'h0604, 1'b0, 32'h0, 1'b0, 32'h0);
        set_enq(1, 16'h0605, 1'b0, 32'h0, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_enq_rdy", 64'(enq_rdy), 64'h0);
        chk("flush_deq_vld", 64'(deq_vld), 64'h0);
        cycle();
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_post_vld", 64'(deq_vld), 64'h0);
        set_enq(0, 16'h0700, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle();
        chk("flush_next_pl", 64'(deq_payload), 64'h0000_0700);
        deq_rdy = 2'b01;
        cycle();

        // Asynchronous reset mid-cycle with count=3
        idle();
        set_enq(0, 16'h0800, 1'b0, 32'h0, 1'b0, 32'h0);
        set_enq(1, 16'h0801, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle();
        set_enq(0, 16'h0802, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle();
        chk("areset_pre_count", 64'(count), 64'd3);
        #3;
        rst = 1'b0;
        #1;
        mq.delete();
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_deq_vld", 64'(deq_vld), 64'h0);
        chk("areset_enq_rdy", 64'(enq_rdy), 64'h3);
        chk("areset_payload", 64'(deq_payload), 64'h0);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_enq(0, 16'h0900, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle();
        chk("areset_resume_pl", 64'(deq_payload), 64'h0000_0900);
        chk("areset_resume_count", 64'(count), 64'd1);
        deq_rdy = 2'b01;
        cycle();

        // Randomized traffic against the model
        repeat (3000) begin
            flush     = ($urandom_range(0, 39) == 0);
            enq_vld   = LANES'($urandom_range(0, 3));
            deq_rdy   = LANES'($urandom_range(0, 3));
            enq_busy1 = LANES'($urandom_range(0, 3));
            enq_busy2 = LANES'($urandom_range(0, 3));
            cdb_vld   = NC'($urandom_range(0, 3));
            for (int k = 0; k < LANES; k++) begin
                enq_payload[k*PW_L +: PW_L] = PW_L'($urandom);
                enq_op1[k*DW +: DW] = $urandom;
                enq_op2[k*DW +: DW] = $urandom;
            end
            for (int c = 0; c < NC; c++) begin
                cdb_tag[c*TW +: TW] = TW'($urandom_range(0, 15));
                cdb_data[c*DW +: DW] = $urandom;
            end
            cycle();
        end
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
